seq_mac_tile_feeder: RTL and testbench

Command-driven sequencer on the initiator side of `seq_MAC`'s operand/result handshakes. It takes a job command (tile count, base address, operand bit sizes) and performs these steps for each tile:
- fetches the A, B and C operand tiles from a fixed-latency operand memory;
- presents them to the MAC through the `valid_in`/`ready_in` handshake;
- collects each D result through `valid_out`/`ready_out`;
- forwards D, with its tile address, to a result writeback port.

---
 rtl/seq_mac_tile_feeder_if.sv | 72 +++++++
 rtl/seq_mac_tile_feeder.sv | 147 ++++++++++++++
 tb/tb_seq_mac_tile_feeder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mac_tile_feeder_if.sv
// Bundles the feeder's command, operand-memory, MAC and writeback signals.
// The master modport is the feeder itself; slave is everything around it.
interface seq_mac_tile_feeder_if #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int P         = 2,
  parameter int ADDR_W    = 8,
  parameter int BSW       = $clog2(MAX_WIDTH/P)+1
);
  logic                                       cmd_valid_i;
  logic                                       cmd_ready_o;
  logic [ADDR_W-1:0]                          cmd_tiles_i;
  logic [ADDR_W-1:0]                          cmd_base_i;
  logic [BSW-1:0]                             cmd_bitsize_a_i;
  logic [BSW-1:0]                             cmd_bitsize_b_i;

  logic                                       mem_req_o;
  logic [ADDR_W-1:0]                          mem_addr_o;
  logic signed [M-1:0][K-1:0][MAX_WIDTH-1:0]  mem_a_i;
  logic signed [K-1:0][N-1:0][MAX_WIDTH-1:0]  mem_b_i;
  logic signed [M-1:0][N-1:0][31:0]           mem_c_i;

  logic [M-1:0][K-1:0][MAX_WIDTH-1:0]         mac_a_o;
  logic [K-1:0][N-1:0][MAX_WIDTH-1:0]         mac_b_o;
  logic [M-1:0][N-1:0][31:0]                  mac_c_o;
  logic [BSW-1:0]                             mac_bitsize_a_o;
  logic [BSW-1:0]                             mac_bitsize_b_o;
  logic                                       mac_valid_o;
  logic                                       mac_ready_i;

  logic [M-1:0][N-1:0][31:0]                  mac_d_i;
  logic                                       mac_valid_i;
  logic                                       mac_ready_o;

  logic                                       res_valid_o;
  logic                                       res_ready_i;
  logic [ADDR_W-1:0]                          res_addr_o;
  logic [M-1:0][N-1:0][31:0]                  res_d_o;

  logic                                       busy_o;
  logic                                       done_o;

  modport master (
    input  cmd_valid_i, cmd_tiles_i, cmd_base_i, cmd_bitsize_a_i, cmd_bitsize_b_i,
    output cmd_ready_o,
    output mem_req_o, mem_addr_o,
    input  mem_a_i, mem_b_i, mem_c_i,
    output mac_a_o, mac_b_o, mac_c_o, mac_bitsize_a_o, mac_bitsize_b_o, mac_valid_o,
    input  mac_ready_i,
    input  mac_d_i, mac_valid_i,
    output mac_ready_o,
    output res_valid_o, res_addr_o, res_d_o,
    input  res_ready_i,
    output busy_o, done_o
  );

  modport slave (
    output cmd_valid_i, cmd_tiles_i, cmd_base_i, cmd_bitsize_a_i, cmd_bitsize_b_i,
    input  cmd_ready_o,
    input  mem_req_o, mem_addr_o,
    output mem_a_i, mem_b_i, mem_c_i,
    input  mac_a_o, mac_b_o, mac_c_o, mac_bitsize_a_o, mac_bitsize_b_o, mac_valid_o,
    output mac_ready_i,
    output mac_d_i, mac_valid_i,
    input  mac_ready_o,
    input  res_valid_o, res_addr_o, res_d_o,
    output res_ready_i,
    input  busy_o, done_o
  );
endinterface

// File: rtl/seq_mac_tile_feeder.sv
// Job sequencer: fetches operand tiles, issues them to the MAC one at a time,
// and forwards each MAC result with its tile address through a one-entry buffer.
module seq_mac_tile_feeder #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int P         = 2,
  parameter int ADDR_W    = 8,
  parameter int BSW       = $clog2(MAX_WIDTH/P)+1
) (
  input logic                   clk_i,
  input logic                   rst_i,
  seq_mac_tile_feeder_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t state, state_n;

  logic [ADDR_W-1:0] tiles_q, base_q, issue_cnt, retire_cnt;
  logic [BSW-1:0]    bsa_q, bsb_q;

  logic [M-1:0][K-1:0][MAX_WIDTH-1:0] a_q;
  logic [K-1:0][N-1:0][MAX_WIDTH-1:0] b_q;
  logic [M-1:0][N-1:0][31:0]          c_q;

  logic                      res_valid_q;
  logic [ADDR_W-1:0]         res_addr_q;
  logic [M-1:0][N-1:0][31:0] res_d_q;
  logic                      done_q;

  logic cmd_ready, mem_req, mac_valid, busy;
  logic cmd_fire, issue_fire, res_load, res_take, mac_ready;
  logic [ADDR_W:0] issue_nxt;

  assign issue_nxt  = {1'b0, issue_cnt} + ONE;
  assign cmd_fire   = cmd_ready & bus.cmd_valid_i;
  assign issue_fire = mac_valid & bus.mac_ready_i;

  // Results seen while idle belong to no job: accept them and drop them.
  assign mac_ready = (state == S_IDLE) | ~res_valid_q | bus.res_ready_i;
  assign res_load  = bus.mac_valid_i & mac_ready & (state != S_IDLE);
  assign res_take  = res_valid_q & bus.res_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    mac_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (bus.cmd_valid_i)
          state_n = (bus.cmd_tiles_i == '0) ? S_DRAIN : S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: state_n = S_ISSUE;
      S_ISSUE: begin
        mac_valid = 1'b1;
        if (bus.mac_ready_i)
          state_n = (issue_nxt < {1'b0, tiles_q}) ? S_FETCH : S_DRAIN;
      end
      S_DRAIN: begin
        if (retire_cnt == tiles_q) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tiles_q    <= '0;
      base_q     <= '0;
      bsa_q      <= '0;
      bsb_q      <= '0;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == S_DRAIN) && (retire_cnt == tiles_q);
      if (cmd_fire) begin
        tiles_q    <= bus.cmd_tiles_i;
        base_q     <= bus.cmd_base_i;
        bsa_q      <= bus.cmd_bitsize_a_i;
        bsb_q      <= bus.cmd_bitsize_b_i;
        issue_cnt  <= '0;
        retire_cnt <= '0;
      end else begin
        if (issue_fire) issue_cnt  <= issue_nxt[ADDR_W-1:0];
        if (res_load)   retire_cnt <= retire_cnt + ADDR_W'(1);
      end
      // Memory read latency is one cycle, so WAIT is the capture cycle.
      if (state == S_WAIT) begin
        a_q <= bus.mem_a_i;
        b_q <= bus.mem_b_i;
        c_q <= bus.mem_c_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_d_q     <= '0;
    end else if (res_load) begin
      res_valid_q <= 1'b1;
      res_addr_q  <= base_q + retire_cnt;
      res_d_q     <= bus.mac_d_i;
    end else if (res_take) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready_o     = cmd_ready;
  assign bus.mem_req_o       = mem_req;
  assign bus.mem_addr_o      = mem_req ? (base_q + issue_cnt) : '0;
  assign bus.mac_a_o         = a_q;
  assign bus.mac_b_o         = b_q;
  assign bus.mac_c_o         = c_q;
  assign bus.mac_bitsize_a_o = bsa_q;
  assign bus.mac_bitsize_b_o = bsb_q;
  assign bus.mac_valid_o     = mac_valid;
  assign bus.mac_ready_o     = mac_ready;
  assign bus.res_valid_o     = res_valid_q;
  assign bus.res_addr_o      = res_addr_q;
  assign bus.res_d_o         = res_d_q;
  assign bus.busy_o          = busy;
  assign bus.done_o          = done_q;

endmodule

// File: tb/tb_seq_mac_tile_feeder.sv
// Scoreboard bench: memory and MAC models around the feeder; expected fetch,
// issue and result addresses are queued by the stimulus and popped by monitors.
module tb_seq_mac_tile_feeder;
  typedef logic [1:0][1:0][15:0] ab_t;
  typedef logic [1:0][1:0][31:0] cd_t;
  typedef struct { logic [127:0] d; int due; } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mac_tile_feeder_if bus();
  seq_mac_tile_feeder dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_req = 0, n_issue = 0, n_done = 0;
  int mac_lat = 4;
  logic [3:0] exp_bsa = '0, exp_bsb = '0;
  logic [7:0] q_fetch[$], q_issue[$], q_res[$];
  pend_t pq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic ab_t fa(input logic [7:0] ad);
    ab_t r;
    for (int m = 0; m < 2; m++) for (int k = 0; k < 2; k++) r[m][k] = {ad, 4'(m), 4'(k)};
    return r;
  endfunction
  function automatic ab_t fb(input logic [7:0] ad);
    ab_t r;
    for (int k = 0; k < 2; k++) for (int n = 0; n < 2; n++) r[k][n] = {~ad, 4'(k), 4'(n)};
    return r;
  endfunction
  function automatic cd_t fc(input logic [7:0] ad);
    cd_t r;
    for (int m = 0; m < 2; m++) for (int n = 0; n < 2; n++) r[m][n] = {ad, 8'hC0, 8'(m), 8'(n)};
    return r;
  endfunction
  function automatic cd_t fd(input logic [7:0] ad);
    cd_t r;
    r = fc(ad);
    for (int m = 0; m < 2; m++) for (int n = 0; n < 2; n++) r[m][n] = r[m][n] + 32'd7;
    return r;
  endfunction

  // Operand memory: one-cycle read latency, data derived from the requested address.
  initial begin
    logic [7:0] ad, sa;
    bus.mem_a_i = '0; bus.mem_b_i = '0; bus.mem_c_i = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_o) begin
        n_req++;
        sa = bus.mem_addr_o;
        if (q_fetch.size() == 0) bad("unexpected_fetch");
        else begin ad = q_fetch.pop_front(); chk("fetch_addr", sa, ad); end
        @(posedge clk); #1;
        bus.mem_a_i = fa(sa); bus.mem_b_i = fb(sa); bus.mem_c_i = fc(sa);
      end
    end
  end

  // MAC model: checks issued operands, returns D = C + 7 after mac_lat cycles.
  initial begin
    logic [7:0] ad;
    cd_t cc;
    pend_t p;
    bus.mac_valid_i = 1'b0; bus.mac_d_i = '0;
    forever begin
      @(negedge clk);
      if (bus.mac_valid_o && bus.mac_ready_i) begin
        n_issue++;
        if (q_issue.size() == 0) bad("unexpected_issue");
        else begin
          ad = q_issue.pop_front();
          chk("mac_a", bus.mac_a_o, fa(ad));
          chk("mac_b", bus.mac_b_o, fb(ad));
          chk("mac_c", bus.mac_c_o, fc(ad));
          chk("mac_bsa", bus.mac_bitsize_a_o, exp_bsa);
          chk("mac_bsb", bus.mac_bitsize_b_o, exp_bsb);
        end
        cc = bus.mac_c_o;
        for (int m = 0; m < 2; m++) for (int n = 0; n < 2; n++) cc[m][n] = cc[m][n] + 32'd7;
        p.d = cc; p.due = cyc + mac_lat;
        pq.push_back(p);
      end
      if (bus.mac_valid_i && bus.mac_ready_o && pq.size() > 0) void'(pq.pop_front());
      @(posedge clk); #1;
      if (pq.size() > 0 && cyc >= pq[0].due) begin
        bus.mac_valid_i = 1'b1; bus.mac_d_i = pq[0].d;
      end else begin
        bus.mac_valid_i = 1'b0;
      end
    end
  end

  // Writeback monitor.
  initial begin
    logic [7:0] ad;
    forever begin
      @(negedge clk);
      if (bus.done_o) n_done++;
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (q_res.size() == 0) bad("unexpected_result");
        else begin
          ad = q_res.pop_front();
          chk("res_addr", bus.res_addr_o, ad);
          chk("res_d", bus.res_d_o, fd(ad));
        end
      end
    end
  end

  task automatic expect_tiles(input logic [7:0] base, input int tiles);
    for (int i = 0; i < tiles; i++) begin
      q_fetch.push_back(base + 8'(i));
      q_issue.push_back(base + 8'(i));
      q_res.push_back(base + 8'(i));
    end
  endtask

  // Returns at 1ns into cycle t+1, where t is the command handshake cycle.
  task automatic send_cmd(input logic [7:0] tiles, input logic [7:0] base,
                          input logic [3:0] bsa, input logic [3:0] bsb);
    int k;
    exp_bsa = bsa; exp_bsb = bsb;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1; bus.cmd_tiles_i = tiles; bus.cmd_base_i = base;
    bus.cmd_bitsize_a_i = bsa; bus.cmd_bitsize_b_i = bsb;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) break;
    end
    if (k == 200) bad("cmd_timeout");
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done_o) break;
    end
    if (k == budget) bad("done_timeout");
  endtask

  task automatic wait_drained();
    for (int k = 0; k < 200 && q_res.size() != 0; k++) @(negedge clk);
    chk("results_drained", q_res.size(), 0);
  endtask

  task automatic wait_mac_valid();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.mac_valid_o) break;
    end
    if (k == 100) bad("mac_valid_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, i0, k;
    bus.cmd_valid_i = 1'b0; bus.cmd_tiles_i = '0; bus.cmd_base_i = '0;
    bus.cmd_bitsize_a_i = '0; bus.cmd_bitsize_b_i = '0;
    bus.mac_ready_i = 1'b1; bus.res_ready_i = 1'b1;

    // Reset values
    #2;
    chk("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
    chk("rst_mac_ready", bus.mac_ready_o, 1'b1);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_mem_req", bus.mem_req_o, 1'b0);
    chk("rst_mac_valid", bus.mac_valid_o, 1'b0);
    chk("rst_res_valid", bus.res_valid_o, 1'b0);
    chk("rst_res_addr", bus.res_addr_o, 8'h00);
    chk("rst_mac_a", bus.mac_a_o, 64'h0);
    chk("rst_done", bus.done_o, 1'b0);
    @(posedge clk); #1; rst = 1'b0;

    // Single tile, base 5, latency 10
    mac_lat = 10;
    expect_tiles(8'h05, 1);
    send_cmd(8'd1, 8'h05, 4'd3, 4'd5);
    @(negedge clk);
    chk("t1_mem_req", bus.mem_req_o, 1'b1);
    chk("t1_mem_addr", bus.mem_addr_o, 8'h05);
    @(negedge clk);
    chk("t2_mac_valid", bus.mac_valid_o, 1'b0);
    @(negedge clk);
    chk("t3_mac_valid", bus.mac_valid_o, 1'b1);
    wait_done(100);
    wait_drained();

    // MAC stall for 7 cycles
    mac_lat = 3;
    i0 = n_issue;
    bus.mac_ready_i = 1'b0;
    expect_tiles(8'h20, 1);
    send_cmd(8'd1, 8'h20, 4'd4, 4'd2);
    wait_mac_valid();
    for (int i = 0; i < 7; i++) begin
      if (i != 0) @(negedge clk);
      chk("stall_valid", bus.mac_valid_o, 1'b1);
      chk("stall_a", bus.mac_a_o, fa(8'h20));
      chk("stall_c", bus.mac_c_o, fc(8'h20));
    end
    @(posedge clk); #1; bus.mac_ready_i = 1'b1;
    wait_done(100);
    wait_drained();
    chk("stall_one_issue", n_issue - i0, 1);

    // Writeback backpressure with a second result pending
    mac_lat = 2;
    bus.res_ready_i = 1'b0;
    expect_tiles(8'h40, 2);
    send_cmd(8'd2, 8'h40, 4'd1, 4'd1);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.res_valid_o && bus.mac_valid_i) break;
    end
    if (k == 100) bad("bp_timeout");
    chk("bp_mac_ready", bus.mac_ready_o, 1'b0);
    chk("bp_held_addr", bus.res_addr_o, 8'h40);
    repeat (3) @(negedge clk);
    chk("bp_still_held", bus.res_addr_o, 8'h40);
    @(posedge clk); #1; bus.res_ready_i = 1'b1;
    wait_done(100);
    wait_drained();

    // Zero-tile command
    r0 = n_req; i0 = n_issue;
    send_cmd(8'd0, 8'h33, 4'd2, 4'd2);
    @(negedge clk);
    chk("z_t1_busy", bus.busy_o, 1'b1);
    chk("z_t1_done", bus.done_o, 1'b0);
    @(negedge clk);
    chk("z_t2_done", bus.done_o, 1'b1);
    repeat (3) @(negedge clk);
    chk("z_no_fetch", n_req - r0, 0);
    chk("z_no_issue", n_issue - i0, 0);
    chk("z_cmd_ready", bus.cmd_ready_o, 1'b1);

    // Address wrap
    mac_lat = 4;
    expect_tiles(8'hFF, 3);
    send_cmd(8'd3, 8'hFF, 4'd8, 4'd7);
    wait_done(200);
    wait_drained();

    // Reset while ISSUE holds mac_valid
    bus.mac_ready_i = 1'b0;
    expect_tiles(8'h70, 2);
    send_cmd(8'd2, 8'h70, 4'd2, 4'd3);
    wait_mac_valid();
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("ar_mac_valid", bus.mac_valid_o, 1'b0);
    chk("ar_busy", bus.busy_o, 1'b0);
    chk("ar_cmd_ready", bus.cmd_ready_o, 1'b1);
    chk("ar_mac_a", bus.mac_a_o, 64'h0);
    chk("ar_mem_req", bus.mem_req_o, 1'b0);
    q_fetch.delete(); q_issue.delete(); q_res.delete();
    @(posedge clk); #1; rst = 1'b0; bus.mac_ready_i = 1'b1;
    mac_lat = 3;
    expect_tiles(8'h90, 2);
    send_cmd(8'd2, 8'h90, 4'd5, 4'd6);
    wait_done(200);
    wait_drained();

    repeat (3) @(negedge clk);
    chk("done_count", n_done, 6);
    chk("fetch_queue_empty", q_fetch.size(), 0);
    chk("issue_queue_empty", q_issue.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
